// File: rtl/m62_rom_loader.sv
// ROM download router for the Irem M62 core: splits the HPS ioctl byte stream into
// SDRAM toggle-handshake writes, sound-ROM/PROM write pulses, and owns the core reset.
module m62_rom_loader #(
    parameter int unsigned GFX_BASE   = 32'h0003_0000,
    parameter int unsigned SND_BASE   = 32'h0002_0000,
    parameter int unsigned SND_END    = 32'h0003_0000,
    parameter int unsigned PROM_BASE  = 32'h000A_0000,
    parameter int unsigned PROM_SIZE  = 32'h0000_0920,
    parameter logic [15:0] RESET_HOLD = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_wait,
    input  logic        user_reset,
    output logic        p1_req,
    input  logic        p1_ack,
    output logic [22:0] p1_a,
    output logic [1:0]  p1_ds,
    output logic [15:0] p1_d,
    output logic        p2_req,
    input  logic        p2_ack,
    output logic [22:0] p2_a,
    output logic [1:0]  p2_ds,
    output logic [15:0] p2_d,
    output logic        snd_we,
    output logic [15:0] snd_a,
    output logic [7:0]  snd_d,
    output logic        prom_we,
    output logic [11:0] prom_a,
    output logic [7:0]  prom_d,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overrun
);

    localparam int unsigned AW = 25;
    localparam logic [AW-1:0] GFX_B    = AW'(GFX_BASE);
    localparam logic [AW-1:0] SND_B    = AW'(SND_BASE);
    localparam logic [AW-1:0] SND_E    = AW'(SND_END);
    localparam logic [AW-1:0] PROM_B   = AW'(PROM_BASE);
    localparam logic [AW-1:0] PROM_END = AW'(PROM_BASE + PROM_SIZE);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic        dl_wr_q;
    logic        dl_active_q;
    logic        p2_pend;
    logic        got_byte;
    logic [15:0] rst_cnt;
    logic [15:0] rst_cnt_nxt;

    logic        strobe;
    logic        in_sdram1;
    logic        in_sdram2;
    logic        in_snd;
    logic        in_prom;
    logic        accept;
    logic        ack_done;
    logic        rst_load;
    logic [23:0] gfx_off;
    logic [11:0] prom_off;

    // Strobe edge detect and address decode
    assign strobe    = dl_wr & ~dl_wr_q & dl_active;
    assign in_sdram1 = dl_addr < PROM_B;
    assign in_sdram2 = (dl_addr >= GFX_B) && (dl_addr < PROM_B);
    assign in_snd    = (dl_addr >= SND_B) && (dl_addr < SND_E);
    assign in_prom   = (dl_addr >= PROM_B) && (dl_addr < PROM_END);
    assign gfx_off   = dl_addr[23:0] - GFX_B[23:0];
    assign prom_off  = dl_addr[11:0] - PROM_B[11:0];

    // SDRAM-bound bytes are only taken in IDLE; PROM bytes never need the SDRAM
    assign accept    = strobe & (in_sdram1 ? (state == IDLE) : in_prom);
    assign ack_done  = (p1_ack == p1_req) && (!p2_pend || (p2_ack == p2_req));
    assign rst_load  = user_reset | ~rom_loaded | dl_active;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_wr_q     <= 1'b0;
            dl_active_q <= 1'b0;
        end else begin
            dl_wr_q     <= dl_wr;
            dl_active_q <= dl_active;
        end
    end

    // Handshake FSM and SDRAM port registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dl_wait <= 1'b0;
            overrun <= 1'b0;
            p2_pend <= 1'b0;
            p1_req  <= 1'b0;
            p1_a    <= '0;
            p1_ds   <= '0;
            p1_d    <= '0;
            p2_req  <= 1'b0;
            p2_a    <= '0;
            p2_ds   <= '0;
            p2_d    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe && in_sdram1) begin
                        p1_req  <= ~p1_req;
                        p1_a    <= dl_addr[23:1];
                        p1_ds   <= {dl_addr[0], ~dl_addr[0]};
                        p1_d    <= {dl_data, dl_data};
                        p2_pend <= in_sdram2;
                        if (in_sdram2) begin
                            p2_req <= ~p2_req;
                            p2_a   <= gfx_off[23:1];
                            p2_ds  <= {gfx_off[0], ~gfx_off[0]};
                            p2_d   <= {dl_data, dl_data};
                        end
                        state   <= BUSY;
                        dl_wait <= 1'b1;
                    end
                end
                BUSY: begin
                    if (strobe && in_sdram1) begin
                        overrun <= 1'b1;
                    end
                    if (ack_done) begin
                        state   <= IDLE;
                        dl_wait <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    dl_wait <= 1'b0;
                end
            endcase
        end
    end

    // Sound-ROM and PROM single-cycle writes, independent of the SDRAM handshake
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            snd_we  <= 1'b0;
            snd_a   <= '0;
            snd_d   <= '0;
            prom_we <= 1'b0;
            prom_a  <= '0;
            prom_d  <= '0;
        end else begin
            snd_we  <= 1'b0;
            prom_we <= 1'b0;
            if (strobe && in_snd) begin
                snd_we <= 1'b1;
                snd_a  <= dl_addr[15:0];
                snd_d  <= dl_data;
            end
            if (strobe && in_prom) begin
                prom_we <= 1'b1;
                prom_a  <= prom_off;
                prom_d  <= dl_data;
            end
        end
    end

    // rom_loaded latches at the end of any download that delivered a byte
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            got_byte   <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            if (dl_active_q && !dl_active) begin
                got_byte <= 1'b0;
                if (got_byte || accept) begin
                    rom_loaded <= 1'b1;
                end
            end else if (accept) begin
                got_byte <= 1'b1;
            end
        end
    end

    always_comb begin
        rst_cnt_nxt = rst_cnt;
        if (rst_load) begin
            rst_cnt_nxt = RESET_HOLD;
        end else if (rst_cnt != 16'd0) begin
            rst_cnt_nxt = rst_cnt - 16'd1;
        end
    end

    // Stretched core reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt    <= RESET_HOLD;
            core_reset <= 1'b1;
        end else begin
            rst_cnt    <= rst_cnt_nxt;
            core_reset <= (rst_cnt_nxt != 16'd0);
        end
    end

endmodule

// File: tb/tb_m62_rom_loader.sv
// Scoreboard bench for m62_rom_loader: directed byte writes push expected port
// transactions; a monitor pops them whenever the DUT toggles a req or pulses a write.
module tb_m62_rom_loader;

    localparam logic [15:0] HOLD = 16'd16;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } port_t;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } snd_t;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } prom_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        dl_wait;
    logic        user_reset = 1'b0;
    logic        p1_req, p2_req;
    logic        p1_ack = 1'b0;
    logic        p2_ack = 1'b0;
    logic [22:0] p1_a, p2_a;
    logic [1:0]  p1_ds, p2_ds;
    logic [15:0] p1_d, p2_d;
    logic        snd_we, prom_we;
    logic [15:0] snd_a;
    logic [7:0]  snd_d, prom_d;
    logic [11:0] prom_a;
    logic        rom_loaded, core_reset, overrun;

    int checks = 0;
    int errors = 0;

    port_t q1[$];
    port_t q2[$];
    snd_t  qs[$];
    prom_t qp[$];

    m62_rom_loader #(.RESET_HOLD(HOLD)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_wait    (dl_wait),
        .user_reset (user_reset),
        .p1_req     (p1_req),
        .p1_ack     (p1_ack),
        .p1_a       (p1_a),
        .p1_ds      (p1_ds),
        .p1_d       (p1_d),
        .p2_req     (p2_req),
        .p2_ack     (p2_ack),
        .p2_a       (p2_a),
        .p2_ds      (p2_ds),
        .p2_d       (p2_d),
        .snd_we     (snd_we),
        .snd_a      (snd_a),
        .snd_d      (snd_d),
        .prom_we    (prom_we),
        .prom_a     (prom_a),
        .prom_d     (prom_d),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset),
        .overrun    (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        tick();
        dl_wr   = 1'b0;
    endtask

    // Controller model: acks toggle d1/d2 cycles after the req becomes visible
    task automatic run_ack(input string name, input int d1, input int d2, input int exp_n);
        int n = 0;
        bit done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c == 1 + d1) p1_ack = ~p1_ack;
            if (d2 >= 0 && c == 1 + d2) p2_ack = ~p2_ack;
            if (dl_wait) begin
                n++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    task automatic count_core_reset(input string name, input int exp_n);
        int n = 0;
        while (core_reset && n < 100) begin
            n++;
            tick();
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    // Monitor: every req toggle / write pulse consumes one expected transaction
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev1 = p1_req;
            prev2 = p2_req;
        end else begin
            if (p1_req !== prev1) begin
                if (q1.size() == 0) begin
                    chk("p1_unexpected_toggle", 64'(p1_a), 64'h7FFFFFFF);
                end else begin
                    port_t e;
                    e = q1.pop_front();
                    chk("p1_a", 64'(p1_a), 64'(e.a));
                    chk("p1_ds", 64'(p1_ds), 64'(e.ds));
                    chk("p1_d", 64'(p1_d), 64'(e.d));
                end
            end
            if (p2_req !== prev2) begin
                if (q2.size() == 0) begin
                    chk("p2_unexpected_toggle", 64'(p2_a), 64'h7FFFFFFF);
                end else begin
                    port_t e;
                    e = q2.pop_front();
                    chk("p2_a", 64'(p2_a), 64'(e.a));
                    chk("p2_ds", 64'(p2_ds), 64'(e.ds));
                    chk("p2_d", 64'(p2_d), 64'(e.d));
                end
            end
            if (snd_we) begin
                if (qs.size() == 0) begin
                    chk("snd_unexpected_we", 64'(snd_a), 64'h7FFFFFFF);
                end else begin
                    snd_t e;
                    e = qs.pop_front();
                    chk("snd_a", 64'(snd_a), 64'(e.a));
                    chk("snd_d", 64'(snd_d), 64'(e.d));
                end
            end
            if (prom_we) begin
                if (qp.size() == 0) begin
                    chk("prom_unexpected_we", 64'(prom_a), 64'h7FFFFFFF);
                end else begin
                    prom_t e;
                    e = qp.pop_front();
                    chk("prom_a", 64'(prom_a), 64'(e.a));
                    chk("prom_d", 64'(prom_d), 64'(e.d));
                end
            end
            prev1 = p1_req;
            prev2 = p2_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset_n = 1'b0;
        #2;
        chk("rst_p1_req", 64'(p1_req), 64'h0);
        chk("rst_p2_req", 64'(p2_req), 64'h0);
        chk("rst_dl_wait", 64'(dl_wait), 64'h0);
        chk("rst_core_reset", 64'(core_reset), 64'h1);
        chk("rst_rom_loaded", 64'(rom_loaded), 64'h0);
        chk("rst_p1_a", 64'(p1_a), 64'h0);
        tick();
        tick();
        reset_n   = 1'b1;
        dl_active = 1'b1;
        tick();

        // Port1 only, ack 3 cycles after the toggle
        q1.push_back(port_t'{23'h000000, 2'b10, 16'h5A5A});
        send_byte(25'h0000001, 8'h5A);
        chk("t1_req_up", 64'(p1_req), 64'h1);
        chk("t1_p2_req_hold", 64'(p2_req), 64'h0);
        run_ack("t1_wait_cycles", 3, -1, 4);

        // Graphics byte goes to both ports; later p2 ack governs dl_wait
        q1.push_back(port_t'{23'h018001, 2'b10, 16'h6B6B});
        q2.push_back(port_t'{23'h000001, 2'b10, 16'h6B6B});
        send_byte(25'h0030003, 8'h6B);
        run_ack("t2_wait_cycles", 1, 6, 7);

        // Sound-CPU ROM byte also lands in port1
        qs.push_back(snd_t'{16'hABCD, 8'hC3});
        q1.push_back(port_t'{23'h0155E6, 2'b10, 16'hC3C3});
        send_byte(25'h002ABCD, 8'hC3);
        run_ack("t3_wait_cycles", 1, -1, 2);

        // PROM byte: pulse only
        qp.push_back(prom_t'{12'h905, 8'h77});
        send_byte(25'h00A0905, 8'h77);
        chk("t3_prom_no_wait", 64'(dl_wait), 64'h0);
        tick();
        tick();

        // First address past the PROM region is dropped
        send_byte(25'h00A0920, 8'h99);
        chk("t4_oob_wait0", 64'(dl_wait), 64'h0);
        tick();
        chk("t4_oob_wait1", 64'(dl_wait), 64'h0);
        chk("t4_overrun_clear", 64'(overrun), 64'h0);
        tick();

        // Strobe while BUSY is dropped and flagged
        q1.push_back(port_t'{23'h000008, 2'b01, 16'h1111});
        send_byte(25'h0000010, 8'h11);
        tick();
        send_byte(25'h0000020, 8'h22);
        chk("t5_overrun", 64'(overrun), 64'h1);
        chk("t5_p1_a_kept", 64'(p1_a), 64'h000008);
        run_ack("t5_wait_cycles", 1, -1, 2);
        q1.push_back(port_t'{23'h000010, 2'b10, 16'h3333});
        send_byte(25'h0000021, 8'h33);
        run_ack("t5_after_wait", 1, -1, 2);
        chk("t5_overrun_sticky", 64'(overrun), 64'h1);

        // Four-byte download, then dl_active falls
        chk("t6_not_loaded", 64'(rom_loaded), 64'h0);
        for (int i = 0; i < 4; i++) begin
            logic [24:0] a;
            logic [7:0]  d;
            a = 25'h4 + 25'(i);
            d = 8'h01 + 8'(i);
            q1.push_back(port_t'{23'(a >> 1), {a[0], ~a[0]}, {d, d}});
            send_byte(a, d);
            run_ack("t6_wait_cycles", 1, -1, 2);
        end
        dl_active = 1'b0;
        chk("t6_loaded_before_edge", 64'(rom_loaded), 64'h0);
        tick();
        chk("t6_loaded", 64'(rom_loaded), 64'h1);
        count_core_reset("t6_core_reset_len", 16);
        chk("t6_core_reset_low", 64'(core_reset), 64'h0);

        // User reset pulse
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        chk("t7_core_reset_up", 64'(core_reset), 64'h1);
        count_core_reset("t7_core_reset_len", 16);

        // Asynchronous reset in the middle of a handshake
        dl_active = 1'b1;
        q1.push_back(port_t'{23'h018000, 2'b01, 16'hEEEE});
        q2.push_back(port_t'{23'h000000, 2'b01, 16'hEEEE});
        send_byte(25'h0030000, 8'hEE);
        tick();
        chk("t8_busy", 64'(dl_wait), 64'h1);
        reset_n = 1'b0;
        p1_ack  = 1'b0;
        p2_ack  = 1'b0;
        #2;
        chk("t8_p1_req", 64'(p1_req), 64'h0);
        chk("t8_p2_req", 64'(p2_req), 64'h0);
        chk("t8_dl_wait", 64'(dl_wait), 64'h0);
        chk("t8_rom_loaded", 64'(rom_loaded), 64'h0);
        chk("t8_overrun", 64'(overrun), 64'h0);
        chk("t8_core_reset", 64'(core_reset), 64'h1);
        chk("t8_p1_a", 64'(p1_a), 64'h0);
        chk("t8_p2_d", 64'(p2_d), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // FSM back in IDLE: next byte accepted normally
        q1.push_back(port_t'{23'h000001, 2'b01, 16'h4444});
        send_byte(25'h0000002, 8'h44);
        run_ack("t8_after_wait", 2, -1, 3);
        tick();
        tick();

        chk("q1_drained", 64'(q1.size()), 64'h0);
        chk("q2_drained", 64'(q2.size()), 64'h0);
        chk("qs_drained", 64'(qs.size()), 64'h0);
        chk("qp_drained", 64'(qp.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m62_rom_loader.md
# m62_rom_loader

ROM download router between the HPS ioctl byte stream and the Irem M62 memory system. It edge-detects download strobes and decodes each byte's address into a region. It then issues toggle-handshake writes to SDRAM port1 (CPU/all ROM) and port2 (sprite/char graphics), plus single-cycle writes to the sound-ROM DPRAM and the colour/height PROM bus. It owns `rom_loaded` and the stretched core reset that gates `target_top`.

## Interface
- `GFX_BASE`, 'h30000, first byte of the graphics region; port2 address = `dl_addr - GFX_BASE`
- `SND_BASE`, 'h20000, first byte of the sound-CPU ROM region
- `SND_END`, 'h30000, first byte past the sound-CPU ROM region
- `PROM_BASE`, 'hA0000, first byte of the PROM region; also the end of SDRAM-bound data
- `PROM_SIZE`, 'h920, PROM region length in bytes
- `RESET_HOLD`, 16'hFFFF, core-reset stretch in clk_sys cycles
- `clk_sys`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `dl_active`  in  1  download of ROM index 0 in progress
- `dl_wr`  in  1  byte strobe, level; edge-detected internally
- `dl_addr`  in  25  byte address
- `dl_data`  in  8  byte data
- `dl_wait`  out  1  backpressure to the HPS; high while an SDRAM write is outstanding
- `user_reset`  in  1  OSD/button reset request
- `p1_req`  out  1  port1 toggle request
- `p1_ack`  in  1  port1 toggle acknowledge
- `p1_a`  out  23  port1 word address
- `p1_ds`  out  2  port1 byte strobes
- `p1_d`  out  16  port1 data
- `p2_req`, `p2_ack`, `p2_a`, `p2_ds`, `p2_d`  as port1, for port2
- `snd_we`  out  1  sound-ROM write pulse
- `snd_a`  out  16  sound-ROM address
- `snd_d`  out  8  sound-ROM data
- `prom_we`  out  1  PROM write pulse
- `prom_a`  out  12  PROM address
- `prom_d`  out  8  PROM data
- `rom_loaded`  out  1  at least one complete download has finished
- `core_reset`  out  1  active-high reset to the game core
- `overrun`  out  1  sticky: strobe arrived while busy

## Operation
- Strobe = `dl_wr & ~dl_wr_q & dl_active`. `dl_wr_q` is registered every cycle and reset to 0.
- Decode on strobe with A = `dl_addr`:
  - SDRAM1 = A < PROM_BASE
  - SDRAM2 = GFX_BASE ≤ A < PROM_BASE
  - SND = SND_BASE ≤ A < SND_END
  - PROM = PROM_BASE ≤ A < PROM_BASE+PROM_SIZE
  - Address ≥ PROM_BASE+PROM_SIZE: byte dropped, no output activity, no wait.
- Port registers, loaded on strobe and held until the next strobe:
  - p1_a = A[23:1]; p1_ds = {A[0],~A[0]}; p1_d = {dl_data,dl_data}.
  - Port2 uses A' = A - GFX_BASE, truncated to 24 bits.
- snd_a = A[15:0]; prom_a = (A-PROM_BASE)[11:0].
- FSM states IDLE and BUSY:
  - IDLE, strobe with SDRAM1: toggle p1_req; toggle p2_req if SDRAM2; go to BUSY; dl_wait←1.
  - IDLE, strobe without SDRAM1: stay in IDLE.
  - BUSY: leave when p1_ack==p1_req and (p2_req==p2_ack or no port2 write pending), then go to IDLE with dl_wait←0.
  - BUSY, strobe: byte dropped, `overrun`←1 (sticky until reset_n).
- snd_we/prom_we: registered one-cycle pulses on the strobe edge. They fire in IDLE or BUSY and are not blocked by BUSY.
- rom_loaded: set on the falling edge of dl_active if ≥1 strobe was accepted during that download. Cleared only by reset_n.
- core_reset counter:
  - Loaded with RESET_HOLD while user_reset | ~rom_loaded | dl_active.
  - Otherwise decrements to 0.
  - core_reset = counter≠0 (registered).
- dl_active falling while BUSY: the FSM completes the outstanding handshake normally.

## Timing
- Reset values:
  - p1_req=p2_req=0
  - dl_wait=0
  - snd_we=prom_we=0
  - all address/data outputs 0
  - rom_loaded=0
  - overrun=0
  - core_reset=1, counter=RESET_HOLD
  - FSM=IDLE
- Strobe seen in cycle N (dl_wr high in N, low in N-1): req toggle, address/data registers, dl_wait and write pulses are all visible from N+1.
- snd_we/prom_we are high for exactly cycle N+1.
- Ack match observed in cycle M: dl_wait low and FSM IDLE from M+1. A strobe in M+1 is accepted.
- Minimum SDRAM byte spacing is 2 cycles when ack returns the cycle after req.
- core_reset falls exactly RESET_HOLD cycles after the first cycle in which the load condition is false.
- reset_n asserted mid-handshake: all state is cleared immediately. The SDRAM controller must be reset by the same reset_n so its ack returns to 0.

## Test plan
- Byte 'h5A at 'h00001, ack returned 3 cycles after the toggle:
  - p1_a=0, p1_ds=2'b10, p1_d='h5A5A, p1_req 0→1.
  - dl_wait high for 4 cycles; p2_req unchanged.
- Byte at 'h30003: p1_a='h18001 and p2_a='h000001 both toggle. dl_wait stays high until the later of the two acks; p2_ack 5 cycles after p1_ack keeps it high through that.
- Byte 'hC3 at 'h2ABCD: snd_we one cycle with snd_a='hABCD, snd_d='hC3, plus a port1 write. A byte at 'hA0905 gives prom_we with prom_a='h905 and no req toggle.
- Byte at 'hA0920: no pulse, no req, dl_wait stays 0.
- Second strobe while BUSY: overrun=1 and the byte is dropped (p1_a unchanged). A later strobe after ack is accepted normally.
- Complete a 4-byte download, with dl_active falling:
  - rom_loaded=1; core_reset falls RESET_HOLD cycles later.
  - Pulse user_reset: core_reset reasserts next cycle and falls RESET_HOLD cycles after release.
  - Assert reset_n mid-BUSY: all outputs take their reset values asynchronously.
